// File: rtl/scan_chain_loader.sv
// scan_chain_loader: serialises a parallel word into the chip scan chain and captures its serial output.
// Outputs are registered from next-state values so chip-facing pins change cleanly on CLK edges.
module scan_chain_loader #(
    parameter int SCAN_LEN      = 64,
    parameter int CLK_DIV       = 4,
    parameter int UPDATE_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [SCAN_LEN-1:0] load_data,
    input  logic                scan_out,
    output logic                se,
    output logic                scanin,
    output logic                scanclk_out,
    output logic                update_clk,
    output logic                busy,
    output logic                scan_done,
    output logic [SCAN_LEN-1:0] readback_data
);
    localparam int PMAX = CLK_DIV > UPDATE_CYCLES ? CLK_DIV : UPDATE_CYCLES;
    localparam int PW   = $clog2(PMAX) + 1;
    localparam int BW   = $clog2(SCAN_LEN) + 1;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, UPDATE, DONE} state_t;
    state_t              state, state_n;
    logic [PW-1:0]       phase, phase_n;
    logic [BW-1:0]       bit_cnt, bit_cnt_n;
    logic [SCAN_LEN-1:0] shift_reg, shift_n, rb_n;
    logic                last_div, last_upd, drive_n;
    assign last_div = phase == PW'(CLK_DIV - 1);
    assign last_upd = phase == PW'(UPDATE_CYCLES - 1);
    assign drive_n  = state_n inside {SETUP, SHIFT_LO, SHIFT_HI};
    always_comb begin
        state_n   = state;
        phase_n   = phase + PW'(1);
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        rb_n      = readback_data;
        case (state)
            IDLE: begin
                phase_n = '0;
                if (load_valid && load_ready) begin
                    state_n   = SETUP;
                    shift_n   = load_data;
                    bit_cnt_n = '0;
                end
            end
            SETUP: if (last_div) begin
                state_n = SHIFT_LO;
                phase_n = '0;
            end
            SHIFT_LO: if (last_div) begin
                state_n = SHIFT_HI;
                phase_n = '0;
                rb_n    = (readback_data << 1) | SCAN_LEN'(scan_out);
            end
            SHIFT_HI: if (last_div) begin
                state_n   = bit_cnt == BW'(SCAN_LEN - 1) ? HOLD : SHIFT_LO;
                phase_n   = '0;
                shift_n   = shift_reg << 1;
                bit_cnt_n = bit_cnt + BW'(1);
            end
            HOLD: if (last_div) begin
                state_n = UPDATE;
                phase_n = '0;
            end
            UPDATE: if (last_upd) begin
                state_n = DONE;
                phase_n = '0;
            end
            DONE: begin
                state_n = IDLE;
                phase_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end
    // load_ready stays low on the first edge out of reset, so no word is accepted then
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state         <= IDLE;
            phase         <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            readback_data <= '0;
            load_ready    <= 1'b0;
            busy          <= 1'b0;
            se            <= 1'b0;
            scanin        <= 1'b0;
            scanclk_out   <= 1'b0;
            update_clk    <= 1'b0;
            scan_done     <= 1'b0;
        end else begin
            state         <= state_n;
            phase         <= phase_n;
            bit_cnt       <= bit_cnt_n;
            shift_reg     <= shift_n;
            readback_data <= rb_n;
            load_ready    <= state_n == IDLE;
            busy          <= state_n != IDLE;
            se            <= drive_n;
            scanin        <= drive_n && shift_n[SCAN_LEN-1];
            scanclk_out   <= state_n == SHIFT_HI;
            update_clk    <= state_n == UPDATE;
            scan_done     <= state_n == DONE;
        end
    end
endmodule
